// File: rtl/bus_edge_pkg.sv
// Shared constants and helpers for the bus line conditioning front end.
package bus_edge_pkg;

    localparam logic        BUS_IDLE_LEVEL  = 1'b1;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_FILT_CYCLES = 3;

    typedef int unsigned width_t;

    // Counter must hold FILT_CYCLES-1 with headroom for the compare.
    function automatic width_t cnt_width(input width_t filt_cycles);
        return width_t'($clog2(filt_cycles)) + width_t'(1);
    endfunction

endpackage

// File: rtl/edge_filter_ch.sv
// One bus line: synchroniser, persistence filter, edge pulses and sticky glitch flag.
module edge_filter_ch
    import bus_edge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned FILT_CYCLES = DEF_FILT_CYCLES,
    parameter logic        RESET_LEVEL = BUS_IDLE_LEVEL
) (
    input  logic clk,
    input  logic n_rst,
    input  logic line_in,
    input  logic filter_en,
    input  logic clr_glitch,
    output logic line_stable,
    output logic rising_edge_found,
    output logic falling_edge_found,
    output logic glitch_flag
);

    localparam int unsigned      CNT_W    = cnt_width(FILT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   stable_nxt;
    logic                   glitch_set;

    assign sync = sync_q[SYNC_STAGES-1];

    // Next stable level and persistence count.
    always_comb begin
        stable_nxt = line_stable;
        cnt_nxt    = cnt;
        glitch_set = 1'b0;
        if (!filter_en) begin
            stable_nxt = sync;
            cnt_nxt    = '0;
        end else if (sync != line_stable) begin
            if (cnt == CNT_LAST) begin
                stable_nxt = sync;
                cnt_nxt    = '0;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else if (cnt != '0) begin
            // Pending change abandoned before it persisted long enough.
            cnt_nxt    = '0;
            glitch_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q             <= {SYNC_STAGES{RESET_LEVEL}};
            cnt                <= '0;
            line_stable        <= RESET_LEVEL;
            rising_edge_found  <= 1'b0;
            falling_edge_found <= 1'b0;
            glitch_flag        <= 1'b0;
        end else begin
            sync_q             <= {sync_q[SYNC_STAGES-2:0], line_in};
            cnt                <= cnt_nxt;
            line_stable        <= stable_nxt;
            rising_edge_found  <= stable_nxt & ~line_stable;
            falling_edge_found <= ~stable_nxt & line_stable;
            glitch_flag        <= glitch_set | (glitch_flag & ~clr_glitch);
        end
    end

endmodule

// File: rtl/bus_edge_filter.sv
// Multi-channel bus line conditioner; one independent filter per line, shared controls.
module bus_edge_filter
    import bus_edge_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned FILT_CYCLES = DEF_FILT_CYCLES,
    parameter logic        RESET_LEVEL = BUS_IDLE_LEVEL
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [NUM_CH-1:0] line_in,
    input  logic              filter_en,
    input  logic              clr_glitch,
    output logic [NUM_CH-1:0] line_stable,
    output logic [NUM_CH-1:0] rising_edge_found,
    output logic [NUM_CH-1:0] falling_edge_found,
    output logic [NUM_CH-1:0] glitch_flag
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        edge_filter_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_ch (
            .clk                (clk),
            .n_rst              (n_rst),
            .line_in            (line_in[i]),
            .filter_en          (filter_en),
            .clr_glitch         (clr_glitch),
            .line_stable        (line_stable[i]),
            .rising_edge_found  (rising_edge_found[i]),
            .falling_edge_found (falling_edge_found[i]),
            .glitch_flag        (glitch_flag[i])
        );
    end

endmodule

// File: tb/tb_bus_edge_filter.sv
// Scoreboard bench for bus_edge_filter: expected edge pulses queued by stimulus, popped by a monitor.
module tb_bus_edge_filter;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [1:0] line_in;
    logic       filter_en;
    logic       clr_glitch;
    logic [1:0] line_stable;
    logic [1:0] rising_edge_found;
    logic [1:0] falling_edge_found;
    logic [1:0] glitch_flag;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int cyc;
        int ch;
        bit rise;
    } exp_t;

    exp_t exp_q[$];

    bus_edge_filter dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .line_in            (line_in),
        .filter_en          (filter_en),
        .clr_glitch         (clr_glitch),
        .line_stable        (line_stable),
        .rising_edge_found  (rising_edge_found),
        .falling_edge_found (falling_edge_found),
        .glitch_flag        (glitch_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at cyc %0d: actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic expect_edge(input int at, input int ch, input bit rise);
        exp_t e;
        e.cyc  = at;
        e.ch   = ch;
        e.rise = rise;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (n_rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missed_edge_cycle", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            for (int ch = 0; ch < 2; ch++) begin
                if (rising_edge_found[ch] && falling_edge_found[ch])
                    chk("edge_exclusive", 1, 0);
                if (rising_edge_found[ch] || falling_edge_found[ch]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_edge_ch", ch, -1);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("edge_cycle", cyc, e.cyc);
                        chk("edge_ch", ch, e.ch);
                        chk("edge_dir_rise", int'(rising_edge_found[ch]), int'(e.rise));
                    end
                end
            end
        end
    end

    initial begin
        n_rst      = 1'b0;
        line_in    = 2'b11;
        filter_en  = 1'b1;
        clr_glitch = 1'b0;

        // Reset state
        step(3);
        chk("rst_stable", int'(line_stable), 3);
        chk("rst_rise", int'(rising_edge_found), 0);
        chk("rst_fall", int'(falling_edge_found), 0);
        chk("rst_glitch", int'(glitch_flag), 0);
        n_rst = 1'b1;
        step(20);
        chk("idle_stable", int'(line_stable), 3);
        chk("idle_glitch", int'(glitch_flag), 0);

        // Filtered falling then rising edge on ch0
        line_in[0] = 1'b0;
        expect_edge(cyc + 5, 0, 1'b0);
        step(4);
        chk("fall_before", int'(line_stable), 3);
        step(1);
        chk("fall_at", int'(line_stable), 2);
        step(6);
        chk("fall_held", int'(line_stable), 2);
        line_in[0] = 1'b1;
        expect_edge(cyc + 5, 0, 1'b1);
        step(8);
        chk("rise_held", int'(line_stable), 3);

        // Two-cycle glitch on ch1 is rejected and flagged
        line_in[1] = 1'b0;
        step(2);
        line_in[1] = 1'b1;
        step(6);
        chk("glitch_flag_set", int'(glitch_flag), 2);
        chk("glitch_stable", int'(line_stable), 3);

        // Second glitch coincident with clear: set wins
        line_in[1] = 1'b0;
        step(2);
        line_in[1] = 1'b1;
        step(2);
        clr_glitch = 1'b1;
        step(1);
        clr_glitch = 1'b0;
        chk("glitch_set_wins", int'(glitch_flag), 2);
        clr_glitch = 1'b1;
        step(1);
        clr_glitch = 1'b0;
        chk("glitch_cleared", int'(glitch_flag), 0);
        step(2);

        // Bypass: every transition passes with 3-edge latency
        filter_en = 1'b0;
        step(2);
        for (int k = 0; k < 4; k++) begin
            line_in[0] = (k % 2) != 0;
            expect_edge(cyc + 3, 0, (k % 2) != 0);
            step(4);
        end
        line_in[0] = 1'b0;
        expect_edge(cyc + 3, 0, 1'b0);
        step(1);
        line_in[0] = 1'b1;
        expect_edge(cyc + 3, 0, 1'b1);
        step(5);
        chk("bypass_glitch", int'(glitch_flag), 0);
        chk("bypass_stable", int'(line_stable), 3);

        // Switching to bypass mid-count accepts the level on the next edge
        filter_en = 1'b1;
        step(2);
        line_in[0] = 1'b0;
        step(3);
        filter_en = 1'b0;
        expect_edge(cyc + 1, 0, 1'b0);
        step(2);
        chk("to_bypass_glitch", int'(glitch_flag), 0);
        chk("to_bypass_stable", int'(line_stable), 2);
        line_in[0] = 1'b1;
        expect_edge(cyc + 3, 0, 1'b1);
        step(5);
        filter_en = 1'b1;
        step(2);

        // Reset while ch0 count is 2: pending change discarded
        line_in[0] = 1'b0;
        step(4);
        n_rst = 1'b0;
        step(1);
        chk("midrst_stable", int'(line_stable), 3);
        chk("midrst_fall", int'(falling_edge_found), 0);
        chk("midrst_glitch", int'(glitch_flag), 0);
        step(1);
        n_rst = 1'b1;
        expect_edge(cyc + 5, 0, 1'b0);
        step(4);
        chk("postrst_before", int'(line_stable), 3);
        step(1);
        chk("postrst_at", int'(line_stable), 2);
        step(5);
        chk("postrst_glitch", int'(glitch_flag), 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
